stamp_conv_sched: RTL
=====================

Name: stamp_conv_sched

Overview:
- Scheduler that shares one multi-cycle unix-stamp-to-calendar converter between two requesters.
- Requester 0 is the live-clock display path: stamp refresh on each second tick.
- Requester 1 is the alarm/time-edit readback path.
- Arbitrates round-robin, issues a start pulse to the converter, waits for done with a watchdog, and returns each requester its own held calendar result.

Parameters:
- STAMP_W, 64, width of unix-second stamp.
- TIMEOUT_CYC, 255, max cycles in WAIT before abort. Range 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has a stamp to convert.
- r0_ready  out  1  requester 0 accepted this cycle.
- r0_stamp  in  STAMP_W  requester 0 stamp.
- r1_valid  in  1  requester 1 request.
- r1_ready  out  1  requester 1 accepted this cycle.
- r1_stamp  in  STAMP_W  requester 1 stamp.
- conv_start  out  1  one-cycle start pulse to converter.
- conv_stamp  out  STAMP_W  stamp presented to converter; held from ISSUE through WAIT.
- conv_done  in  1  converter result valid (one-cycle pulse).
- conv_time  in  TIME_W  packed converter result.
- r0_resp_valid  out  1  one-cycle pulse: r0_time updated.
- r0_time  out  TIME_W  last result delivered to requester 0.
- r1_resp_valid  out  1  one-cycle pulse: r1_time updated.
- r1_time  out  TIME_W  last result delivered to requester 1.
- timeout_err  out  1  sticky: a conversion timed out.

Behaviour:
- Packed time (TIME_W=43), MSB to LSB: year[13:0], month[3:0], day[4:0], weekday[2:0], hour[4:0], minute[5:0], second[5:0].
- Reset (rst=1 at a clock edge) values:
  - state=IDLE, last_grant=1 (so r0 wins first).
  - conv_start=0, conv_stamp=0.
  - All ready/resp_valid outputs=0, r0_time=r1_time=0.
  - timeout_err=0, wait counter=0.
- Reset mid-operation aborts with no response. A conv_done arriving after reset is ignored because state is IDLE.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - rX_ready is combinational and asserted only in IDLE, for the granted requester only.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant.
  - On accept (valid & ready): latch stamp into conv_stamp, latch id, update last_grant, go to ISSUE.
- ISSUE: conv_start=1 for exactly one cycle; clear wait counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - conv_done=1: capture conv_time into r{id}_time, go to DELIVER.
  - Else if counter == TIMEOUT_CYC-1: set timeout_err, go to IDLE; no response, result register unchanged.
  - conv_done and timeout in the same cycle: done wins.
- DELIVER: r{id}_resp_valid=1 for one cycle; go to IDLE. The next accept is possible in the following cycle.
- Latency: accept at cycle N, conv_start at N+1. conv_done at D ≥ N+2 gives rX_time updated and resp_valid asserted at D+1.
- Throughput: one conversion in flight at most.
- conv_done outside WAIT is ignored.
- Requester rules:
  - valid must stay high and stamp stable until ready.
  - Deasserting valid before grant withdraws the request.
  - Stamp value is passed unmodified (no range check).
- rX_time holds until the next delivery to that same requester. The other requester's delivery never alters it.
- timeout_err clears only on rst.

Decomposition:
- Package stamp_conv_pkg:
  - TIME_W=43.
  - Field offsets/widths for year, month, day, weekday, hour, minute, second.
  - State enum {IDLE, ISSUE, WAIT, DELIVER}.
  - Requester id type (1 bit).
- One natural sub-module: rr_arb2, the two-way round-robin grant with last_grant register and update-on-accept input.

Test Plan:
- Single r0 request, stamp 0, converter model done 5 cycles after start.
  - r0_ready at N, conv_start at N+1.
  - r0_resp_valid at N+7 with r0_time year=1970, month=1, day=1, weekday=4, 00:00:00.
  - r1_time stays 0.
- r0 and r1 both valid continuously, stamps 86400 and 951782400.
  - Grants alternate r0, r1, r0.
  - r1_time = 2000-02-29, weekday 2, 00:00:00.
  - No starvation over 8 requests.
- Converter never asserts done, TIMEOUT_CYC=16.
  - FSM returns to IDLE 16 cycles after entering WAIT; timeout_err=1 and stays 1.
  - No resp_valid; next request is still serviced normally.
- conv_done in the same cycle the counter hits TIMEOUT_CYC-1: result delivered, timeout_err stays 0.
- rst asserted in WAIT, then a late conv_done is pulsed.
  - All outputs return to reset values; no resp_valid.
  - The following r1 request is granted first only if r0 is idle; otherwise r0 wins because last_grant reset to 1.
- Spurious conv_done while IDLE: no output change.
- r1_valid dropped before grant: no conversion issued for r1.

Source files
------------

// File: rtl/stamp_conv_pkg.sv
// Shared types for the stamp-to-calendar conversion scheduler.
// Packed time layout, MSB to LSB: year, month, day, weekday, hour, minute, second.
package stamp_conv_pkg;

    localparam int TIME_W = 43;

    localparam int SEC_OFF  = 0;
    localparam int SEC_W    = 6;
    localparam int MIN_OFF  = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_OFF = 12;
    localparam int HOUR_W   = 5;
    localparam int WDAY_OFF = 17;
    localparam int WDAY_W   = 3;
    localparam int DAY_OFF  = 20;
    localparam int DAY_W    = 5;
    localparam int MON_OFF  = 25;
    localparam int MON_W    = 4;
    localparam int YEAR_OFF = 29;
    localparam int YEAR_W   = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/stamp_conv_if.sv
// Requester, converter and status signals of the conversion scheduler.
// The scheduler uses the slave view; the surrounding system uses master.
interface stamp_conv_if
    import stamp_conv_pkg::*;
#(
    parameter int STAMP_W = 64
);
    logic               r0_valid;
    logic               r0_ready;
    logic [STAMP_W-1:0] r0_stamp;
    logic               r1_valid;
    logic               r1_ready;
    logic [STAMP_W-1:0] r1_stamp;
    logic               conv_start;
    logic [STAMP_W-1:0] conv_stamp;
    logic               conv_done;
    logic [TIME_W-1:0]  conv_time;
    logic               r0_resp_valid;
    logic [TIME_W-1:0]  r0_time;
    logic               r1_resp_valid;
    logic [TIME_W-1:0]  r1_time;
    logic               timeout_err;

    modport slave (
        input  r0_valid, r0_stamp, r1_valid, r1_stamp, conv_done, conv_time,
        output r0_ready, r1_ready, conv_start, conv_stamp,
        output r0_resp_valid, r0_time, r1_resp_valid, r1_time, timeout_err
    );

    modport master (
        output r0_valid, r0_stamp, r1_valid, r1_stamp, conv_done, conv_time,
        input  r0_ready, r1_ready, conv_start, conv_stamp,
        input  r0_resp_valid, r0_time, r1_resp_valid, r1_time, timeout_err
    );
endinterface

// File: rtl/stamp_conv_sched_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time
// is granted. last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2
    import stamp_conv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       accept,
    output logic [1:0] grant
);
    req_id_t last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || last_grant == 1'b1))
                grant[0] = 1'b1;
            else if (req[1])
                grant[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant[1];
    end
endmodule

// File: rtl/stamp_conv_sched.sv
// Shares one multi-cycle stamp-to-calendar converter between two requesters,
// with a watchdog on the converter and a per-requester held result.
module stamp_conv_sched
    import stamp_conv_pkg::*;
#(
    parameter int STAMP_W     = 64,
    parameter int TIMEOUT_CYC = 255
)(
    input  logic        clk,
    input  logic        rst,
    stamp_conv_if.slave bus
);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    req_id_t     id;
    logic [15:0] wait_cnt;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        accept;

    assign req    = {bus.r1_valid, bus.r0_valid};
    assign accept = |(grant & req);

    assign bus.r0_ready = grant[0];
    assign bus.r1_ready = grant[1];

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .en     (state == IDLE),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            id                <= 1'b0;
            wait_cnt          <= '0;
            bus.conv_start    <= 1'b0;
            bus.conv_stamp    <= '0;
            bus.r0_resp_valid <= 1'b0;
            bus.r1_resp_valid <= 1'b0;
            bus.r0_time       <= '0;
            bus.r1_time       <= '0;
            bus.timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.conv_stamp <= grant[1] ? bus.r1_stamp : bus.r0_stamp;
                        id             <= grant[1];
                        bus.conv_start <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.conv_start <= 1'b0;
                    wait_cnt       <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // A done on the watchdog's last cycle still counts as success.
                    if (bus.conv_done) begin
                        if (id == 1'b1) begin
                            bus.r1_time       <= bus.conv_time;
                            bus.r1_resp_valid <= 1'b1;
                        end else begin
                            bus.r0_time       <= bus.conv_time;
                            bus.r0_resp_valid <= 1'b1;
                        end
                        state <= DELIVER;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus.timeout_err <= 1'b1;
                        state           <= IDLE;
                    end
                end
                DELIVER: begin
                    bus.r0_resp_valid <= 1'b0;
                    bus.r1_resp_valid <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
